// File: rtl/psram_stub_responder_pkg.sv
// psram_stub_responder_pkg: FSM states and access-duration helper for the PSRAM stub
package psram_stub_responder_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WR, ST_RD} state_t;
  function automatic int dur(input int lat, input logic x2, input logic rd);
    return (x2 ? 2 * lat : lat) + (rd ? 6 : 2);
  endfunction
endpackage

// File: rtl/psram_stub_responder_if.sv
// psram_stub_responder_if: controller-side PSRAM bus; proto_err exists only with PSRAM_STUB_PROTOCOL_CHECK_EN
interface psram_stub_responder_if;
  logic read;
  logic write;
  logic byte_write;
  logic [21:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic busy;
`ifdef PSRAM_STUB_PROTOCOL_CHECK_EN
  logic proto_err;
`endif
  modport master(output read, write, byte_write, addr, din, input dout, busy
`ifdef PSRAM_STUB_PROTOCOL_CHECK_EN
    , input proto_err
`endif
  );
  modport slave(input read, write, byte_write, addr, din, output dout, busy
`ifdef PSRAM_STUB_PROTOCOL_CHECK_EN
    , output proto_err
`endif
  );
endinterface

// File: rtl/psram_stub_responder_ram.sv
// psram_stub_ram: single-port 2^AW x 16 RAM with byte enables and registered read
module psram_stub_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   d,
  output logic [15:0]   q
);
  logic [15:0] mem [0:(1<<AW)-1];
  always_ff @(posedge clk) begin
    if (en && we && be[0]) mem[addr][7:0] <= d[7:0];
    if (en && we && be[1]) mem[addr][15:8] <= d[15:8];
    if (en && !we) q <= mem[addr];
  end
endmodule

// File: rtl/psram_stub_responder.sv
// psram_stub_responder: BRAM-backed PSRAM controller stand-in; PSRAM_STUB_PROTOCOL_CHECK_EN adds sticky proto_err
module psram_stub_responder
  import psram_stub_responder_pkg::*;
#(
  parameter int LATENCY       = 3,
  parameter int INIT_CYCLES   = 16,
  parameter int REFRESH_EVERY = 16,
  parameter int AW_WORDS      = 10
) (
  input logic clk,
  input logic resetn,
  psram_stub_responder_if.slave bus
);
  localparam int CW = $clog2(2 * LATENCY + 7);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int RW = REFRESH_EVERY > 1 ? $clog2(REFRESH_EVERY) : 1;
  state_t st;
  logic [CW-1:0] cnt;
  logic [IW-1:0] icnt;
  logic [RW-1:0] rcnt;
  logic [AW_WORDS:0] a_q;
  logic [15:0] d_q, dout_q, ram_q;
  logic bw_q, busy_q, is2x, ram_en, ram_we;
  logic [1:0] ram_be;
  assign is2x = REFRESH_EVERY != 0 && rcnt == RW'(REFRESH_EVERY - 1);
  assign bus.busy = busy_q;
  assign bus.dout = dout_q;
  // write commits on the completion edge; read is fetched one edge earlier
  assign ram_we = st == ST_WR && cnt == '0 && resetn;
  assign ram_en = ram_we || (st == ST_RD && cnt == CW'(1));
  assign ram_be = bw_q ? (a_q[0] ? 2'b10 : 2'b01) : 2'b11;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st <= ST_INIT;
      busy_q <= 1'b1;
      dout_q <= '0;
      icnt <= '0;
      rcnt <= '0;
      cnt <= '0;
    end else begin
      case (st)
        ST_INIT: begin
          icnt <= icnt + 1'b1;
          if (icnt == IW'(INIT_CYCLES - 1)) begin
            st <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_IDLE: if (bus.read || bus.write) begin
          st <= bus.write ? ST_WR : ST_RD;
          busy_q <= 1'b1;
          a_q <= bus.addr[AW_WORDS:0];
          d_q <= bus.din;
          bw_q <= bus.byte_write;
          cnt <= CW'(dur(LATENCY, is2x, !bus.write) - 1);
          rcnt <= (is2x || REFRESH_EVERY == 0) ? '0 : rcnt + 1'b1;
        end
        default: if (cnt == '0) begin
          st <= ST_IDLE;
          busy_q <= 1'b0;
          if (st == ST_RD) dout_q <= ram_q;
        end else cnt <= cnt - 1'b1;
      endcase
    end
  end
`ifdef PSRAM_STUB_PROTOCOL_CHECK_EN
  logic perr;
  assign bus.proto_err = perr;
  always_ff @(posedge clk) begin
    if (!resetn) perr <= 1'b0;
    else if (((bus.read || bus.write) && busy_q) || (bus.read && bus.write)) perr <= 1'b1;
  end
`endif
  psram_stub_ram #(.AW(AW_WORDS)) u_ram (
    .clk(clk),
    .en(ram_en),
    .we(ram_we),
    .be(ram_be),
    .addr(a_q[AW_WORDS:1]),
    .d(d_q),
    .q(ram_q)
  );
endmodule

// File: tb/tb_psram_stub_responder.sv
// tb_psram_stub_responder: scoreboard bench for psram_stub_responder (optionally with PSRAM_STUB_PROTOCOL_CHECK_EN)
module tb_psram_stub_responder;
  localparam int LAT = 3;
  localparam int RE = 16;
  localparam int AW = 10;
  typedef struct {
    bit rd;
    int dur;
    logic [15:0] data;
    int acc;
  } exp_t;
  logic clk = 0;
  logic resetn = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int rcnt_m = 0;
  logic [15:0] last_rd = '0;
  logic [15:0] mm [int];
  exp_t sbq[$];
  psram_stub_responder_if bus();
  psram_stub_responder #(.LATENCY(LAT), .INIT_CYCLES(16), .REFRESH_EVERY(RE), .AW_WORDS(AW)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    int r;
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 1);
    check("reset_dout", bus.dout, 0);
`ifdef PSRAM_STUB_PROTOCOL_CHECK_EN
    check("reset_proto_err", bus.proto_err, 0);
`endif
    resetn = 1;
    r = cyc;
    while (bus.busy && cyc - r < 64) begin
      @(posedge clk);
      #1;
    end
    check("init_cycles", cyc - r, 16);
    rcnt_m = 0;
    last_rd = '0;
    sbq.delete();
  endtask
  task automatic start_cmd(input bit rd, input bit wr, input bit bw, input logic [21:0] a,
                           input logic [15:0] d, input bit commit);
    exp_t e;
    int i;
    logic [15:0] w;
    bit x2;
    i = int'(a[AW:1]);
    x2 = RE != 0 && rcnt_m == RE - 1;
    rcnt_m = RE == 0 ? 0 : (rcnt_m + 1) % RE;
    e.rd = !wr;
    e.dur = (x2 ? 2 * LAT : LAT) + (wr ? 2 : 6);
    e.data = mm.exists(i) ? mm[i] : 'x;
    if (wr && commit) begin
      w = e.data;
      if (!bw || !a[0]) w[7:0] = d[7:0];
      if (!bw || a[0]) w[15:8] = d[15:8];
      mm[i] = w;
    end
    bus.read = rd;
    bus.write = wr;
    bus.byte_write = bw;
    bus.addr = a;
    bus.din = d;
    @(posedge clk);
    #1;
    e.acc = cyc;
    bus.read = 0;
    bus.write = 0;
    check("busy_rise", bus.busy, 1);
    sbq.push_back(e);
  endtask
  task automatic finish_cmd(input string tag);
    exp_t e;
    e = sbq.pop_front();
    while (bus.busy && cyc - e.acc < 64) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_dur"}, cyc - e.acc, e.dur);
    if (e.rd) last_rd = e.data;
    check({tag, "_dout"}, bus.dout, last_rd);
  endtask
  task automatic cmd(input bit rd, input bit wr, input bit bw, input logic [21:0] a,
                     input logic [15:0] d, input string tag);
    start_cmd(rd, wr, bw, a, d, 1);
    finish_cmd(tag);
  endtask
  initial begin
    bus.read = 0;
    bus.write = 0;
    bus.byte_write = 0;
    bus.addr = '0;
    bus.din = '0;
    @(posedge clk);
    #1;
    do_reset();
    cmd(0, 1, 0, 22'h000010, 16'hA55A, "wr_word");
    cmd(1, 0, 0, 22'h000010, 16'h0000, "rd_word");
    check("rd_word_val", bus.dout, 16'hA55A);
    cmd(0, 1, 1, 22'h000020, 16'h3C3C, "wr_lo");
    cmd(0, 1, 1, 22'h000021, 16'hC3C3, "wr_hi");
    cmd(1, 0, 0, 22'h000020, 16'h0000, "rd_bytes");
    check("rd_bytes_val", bus.dout, 16'hC33C);
`ifdef PSRAM_STUB_PROTOCOL_CHECK_EN
    check("proto_clean", bus.proto_err, 0);
`endif
    cmd(0, 1, 0, 22'h000040, 16'h1111, "wr_40");
    start_cmd(0, 1, 0, 22'h000040, 16'h2222, 0);
    @(posedge clk);
    #1;
    do_reset();
    cmd(1, 0, 0, 22'h000040, 16'h0000, "rd_abort");
    check("rd_abort_val", bus.dout, 16'h1111);
    do_reset();
    for (int k = 0; k < 17; k++)
      cmd(0, 1, 0, 22'h000100 + 22'(2 * k), 16'(k * 16'h0101 + 16'h5000), $sformatf("b2b%0d", k));
    cmd(1, 0, 0, 22'h00011E, 16'h0000, "rd_b2b");
    cmd(0, 1, 0, 22'h0807FE, 16'hBEEF, "wr_alias");
    cmd(1, 0, 0, 22'h0007FE, 16'h0000, "rd_alias");
    check("rd_alias_val", bus.dout, 16'hBEEF);
    start_cmd(1, 0, 0, 22'h000100, 16'h0000, 1);
    bus.write = 1;
    bus.addr = 22'h000100;
    bus.din = 16'hDEAD;
    @(posedge clk);
    #1;
    bus.write = 0;
    finish_cmd("rd_inject");
    cmd(1, 0, 0, 22'h000100, 16'h0000, "rd_after_inject");
    check("inject_ignored", bus.dout, 16'h5000);
    cmd(1, 1, 0, 22'h000300, 16'h7777, "rw_both");
    cmd(1, 0, 0, 22'h000300, 16'h0000, "rd_rw");
    check("rw_as_write", bus.dout, 16'h7777);
`ifdef PSRAM_STUB_PROTOCOL_CHECK_EN
    check("proto_set", bus.proto_err, 1);
    cmd(0, 1, 0, 22'h000302, 16'h1234, "wr_sticky");
    check("proto_sticky", bus.proto_err, 1);
`endif
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
